// File: rtl/relu_activation_unit_pkg.sv
// Shared types and helpers for the multi-lane activation stage.
package relu_pkg;

    typedef enum logic [1:0] {
        RELU_BYPASS = 2'd0,
        RELU_RELU   = 2'd1,
        RELU_LEAKY  = 2'd2,
        RELU_CLAMP  = 2'd3
    } relu_mode_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LANES      = 4;
    localparam int DEF_LEAK_SHIFT = 3;
    localparam int DEF_CNT_WIDTH  = 32;

    // Width-agnostic: callers pass sign/nonzero flags instead of the element.
    function automatic logic lane_is_zeroed(input relu_mode_t mode, input logic x_neg,
                                            input logic x_pos, input logic clamp_zero);
        return ((mode == RELU_RELU || mode == RELU_CLAMP) && x_neg) ||
               (mode == RELU_CLAMP && clamp_zero && x_pos);
    endfunction

endpackage

// File: rtl/relu_activation_unit_if.sv
// Beat-level handshake bundle between upstream, the activation stage and downstream.
interface relu_activation_unit_if
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES
) ();

    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    relu_mode_t                  in_mode;
    logic [DATA_WIDTH-1:0]       cfg_clamp;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_mode, cfg_clamp, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, cfg_clamp, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/relu_activation_unit_lane.sv
// One lane of the activation function: purely combinational.
module relu_lane
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  relu_mode_t                   mode,
    input  logic signed [DATA_WIDTH-1:0] clamp,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         zeroed
);

    logic                         x_neg;
    logic                         x_pos;
    logic signed [DATA_WIDTH-1:0] ceil_c;

    always_comb begin
        x_neg  = x[DATA_WIDTH-1];
        x_pos  = !x_neg && (x != '0);
        // A negative ceiling would make CLAMP produce negatives; floor it at zero.
        ceil_c = clamp[DATA_WIDTH-1] ? '0 : clamp;
        y      = x;
        case (mode)
            RELU_RELU:  y = x_neg ? '0 : x;
            RELU_LEAKY: y = x_neg ? (x >>> LEAK_SHIFT) : x;
            RELU_CLAMP: y = x_neg ? '0 : ((x > ceil_c) ? ceil_c : x);
            default:    y = x;
        endcase
        zeroed = lane_is_zeroed(mode, x_neg, x_pos, ceil_c == '0);
    end

endmodule

// File: rtl/relu_activation_unit.sv
// Two-stage elastic activation pipeline (S1 = activated beat, S2 = output register)
// with a saturating count of lanes forced to zero.
module relu_activation_unit
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    relu_activation_unit_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] zero_count
);

    localparam int W      = LANES * DATA_WIDTH;
    localparam int STAGES = 2;
    localparam int INC_W  = $clog2(LANES + 1);
    localparam int SUM_W  = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;

    logic [LANES-1:0][DATA_WIDTH-1:0] y_lane;
    logic [LANES-1:0]                 zeroed;
    logic [STAGES:1]                  vld_pipe;
    logic [W-1:0]                     s1_data;
    logic [W-1:0]                     s2_data;
    logic                             s1_valid;
    logic                             s2_valid;
    logic                             adv1;
    logic                             adv2;
    logic                             accept;
    logic [INC_W-1:0]                 inc;
    logic [SUM_W-1:0]                 cnt_sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x      (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .mode   (bus.in_mode),
            .clamp  (bus.cfg_clamp),
            .y      (y_lane[i]),
            .zeroed (zeroed[i])
        );
    end

    assign s1_valid      = vld_pipe[1];
    assign s2_valid      = vld_pipe[2];
    assign adv2          = !s2_valid || bus.out_ready;
    assign adv1          = !s1_valid || adv2;
    assign bus.in_ready  = adv1;
    assign accept        = bus.in_valid && adv1;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;

    // Data registers load only on real transfers so idle-bus garbage never enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s2_data  <= '0;
        end else begin
            if (adv1)   vld_pipe[1] <= bus.in_valid;
            if (accept) s1_data     <= y_lane;
            if (adv2)   vld_pipe[2] <= s1_valid;
            if (adv2 && s1_valid) s2_data <= s1_data;
        end
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < LANES; i++) inc = inc + INC_W'(zeroed[i]);
        cnt_sum = SUM_W'(zero_count) + SUM_W'(inc);
    end

    // Clear beats a same-cycle increment; any carry past CNT_WIDTH pins at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            zero_count <= '0;
        else if (accept)
            zero_count <= (|cnt_sum[SUM_W-1:CNT_WIDTH]) ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

endmodule

// File: tb/tb_relu_activation_unit.sv
// Randomised bench for relu_activation_unit against a beat-queue reference model.
module tb_relu_activation_unit;
    import relu_pkg::*;

    localparam int DW   = 16;
    localparam int NL   = 4;
    localparam int LS   = 3;
    localparam int CW   = 4;
    localparam int W    = NL * DW;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0] y;
        int           nz;
        int           acc_cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_clr;
    logic [CW-1:0] zero_count;

    relu_activation_unit_if #(.DATA_WIDTH(DW), .LANES(NL)) bus ();

    relu_activation_unit #(
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .LEAK_SHIFT (LS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .zero_count (zero_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int act_fn(input int x, input int m, input int c);
        int cc;
        case (m)
            1:       return (x < 0) ? 0 : x;
            2:       return (x < 0) ? (x - ((1 << LS) - 1)) / (1 << LS) : x;
            3: begin
                cc = (c < 0) ? 0 : c;
                return (x < 0) ? 0 : ((x < cc) ? x : cc);
            end
            default: return x;
        endcase
    endfunction

    function automatic beat_t model_beat(input logic [W-1:0] d, input int m, input logic [DW-1:0] c);
        beat_t             b;
        logic signed [DW-1:0] t;
        logic signed [DW-1:0] cs;
        int x, y;
        b.y  = '0;
        b.nz = 0;
        b.acc_cyc = 0;
        cs = c;
        for (int i = 0; i < NL; i++) begin
            t = d[i*DW +: DW];
            x = t;
            y = act_fn(x, m, cs);
            b.y[i*DW +: DW] = DW'(y);
            if (x != 0 && y == 0) b.nz++;
        end
        return b;
    endfunction

    beat_t        q[$];
    int           cyc = 0;
    int           m_cnt = 0;
    logic         p_acc = 0, p_pop = 0, p_rst = 1, p_clr = 0;
    logic [W-1:0] p_data;
    int           p_mode;
    logic [DW-1:0] p_clamp;

    // Snapshot the cycle's transfers mid-cycle, from the model's view of readiness.
    always @(negedge clk) begin
        logic e_vld, e_rdy;
        #1;
        e_vld = (q.size() > 0) && (q[0].acc_cyc < cyc);
        e_rdy = (q.size() < 2) || bus.out_ready;
        if (cyc > 0) chk("in_ready", W'(bus.in_ready), W'(e_rdy));
        p_acc   = bus.in_valid && e_rdy;
        p_pop   = e_vld && bus.out_ready;
        p_rst   = rst;
        p_clr   = cnt_clr;
        p_data  = bus.in_data;
        p_mode  = int'(bus.in_mode);
        p_clamp = bus.cfg_clamp;
    end

    always @(posedge clk) begin
        beat_t b;
        logic  e_vld;
        int    nz;
        cyc++;
        if (p_rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (p_pop) q.delete(0);
            nz = 0;
            if (p_acc) begin
                b = model_beat(p_data, p_mode, p_clamp);
                b.acc_cyc = cyc;
                q.push_back(b);
                nz = b.nz;
            end
            if (p_clr) m_cnt = 0;
            else       m_cnt = (m_cnt + nz > CMAX) ? CMAX : m_cnt + nz;
        end
        #1;
        e_vld = (q.size() > 0) && (q[0].acc_cyc < cyc);
        chk("out_valid", W'(bus.out_valid), W'(e_vld));
        if (e_vld) chk("out_data", bus.out_data, q[0].y);
        chk("zero_count", W'(zero_count), W'(m_cnt));
    end

    // ---------------- stimulus ----------------
    logic         obs_v, obs_rdy, obs_acc;
    logic [W-1:0] obs_d;

    function automatic logic [W-1:0] pk(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [DW-1:0] rv();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h0001;
            4: return 16'h7FFF;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] rclamp();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFC;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return DW'($urandom_range(0, 2000));
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input int m, input logic [DW-1:0] c,
                         input logic ordy, input logic clr, input logic r);
        @(negedge clk);
        bus.in_valid  = v;
        // Idle cycles carry junk so ignoring it is actually exercised.
        bus.in_data   = v ? d : {rv(), rv(), rv(), rv()};
        bus.in_mode   = v ? relu_mode_t'(m[1:0]) : relu_mode_t'($urandom_range(0, 3));
        bus.cfg_clamp = v ? c : rclamp();
        bus.out_ready = ordy;
        cnt_clr       = clr;
        rst           = r;
        #2;
        obs_v   = bus.out_valid;
        obs_d   = bus.out_data;
        obs_rdy = bus.in_ready;
        obs_acc = v && bus.in_ready;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, 0, '0, ordy, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, bb, cdat, nb, d;
        int           k, m;
        logic [DW-1:0] c;
        logic         v;

        rst = 1'b1; cnt_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = RELU_BYPASS;
        bus.cfg_clamp = '0; bus.out_ready = 1'b1;

        repeat (3) drive(1'b0, '0, 0, '0, 1'b1, 1'b0, 1'b1);
        settle();
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_count", W'(zero_count), W'(0));
        idle(1'b1);
        chk("rdy_after_rst", W'(obs_rdy), W'(1));

        // 1: RELU
        drive(1'b1, pk(-5, 0, 7, -32768), 1, '0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t1_count", W'(zero_count), W'(2));
        idle(1'b1);
        chk("t1_not_yet", W'(obs_v), W'(0));
        idle(1'b1);
        chk("t1_valid", W'(obs_v), W'(1));
        chk("t1_data", obs_d, pk(0, 0, 7, 0));

        // 2: LEAKY
        drive(1'b1, pk(-16, -1, 100, -32768), 2, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("t2_data", obs_d, pk(-2, -1, 100, -4096));
        settle();
        chk("t2_count", W'(zero_count), W'(2));

        // 3: CLAMP with positive then negative ceiling
        drive(1'b1, pk(2000, 1536, -3, 10), 3, 16'd1536, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t3a_count", W'(zero_count), W'(3));
        drive(1'b1, pk(2000, 1536, -3, 10), 3, 16'hFFFC, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("t3a_data", obs_d, pk(1536, 1536, 0, 10));
        settle();
        chk("t3b_count", W'(zero_count), W'(7));
        idle(1'b1);
        chk("t3b_data", obs_d, pk(0, 0, 0, 0));

        // 4: stall with a full pipeline
        a = pk(1, 2, 3, 4); bb = pk(5, 6, 7, 8); cdat = pk(9, 10, 11, 12);
        drive(1'b1, a, 0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, bb, 0, '0, 1'b0, 1'b0, 1'b0);
        chk("t4_b_acc", W'(obs_acc), W'(1));
        repeat (5) begin
            drive(1'b1, cdat, 0, '0, 1'b0, 1'b0, 1'b0);
            chk("t4_stall_rdy", W'(obs_rdy), W'(0));
            chk("t4_hold_a", obs_d, a);
        end
        drive(1'b1, cdat, 0, '0, 1'b1, 1'b0, 1'b0);
        chk("t4_c_acc", W'(obs_acc), W'(1));
        chk("t4_out_a", obs_d, a);
        idle(1'b1);
        chk("t4_out_b", obs_d, bb);
        idle(1'b1);
        chk("t4_out_c", {obs_v, obs_d[W-2:0]}, {1'b1, cdat[W-2:0]});
        idle(1'b1);
        chk("t4_drained", W'(obs_v), W'(0));

        // 5: mode rotates every beat over shared data, random backpressure
        k = 0;
        d = '0; c = '0;
        while (k < 48) begin
            if (k % 4 == 0) begin
                d = {rv(), rv(), rv(), rv()};
                c = rclamp();
            end
            v = ($urandom_range(0, 9) < 8);
            drive(v, d, k % 4, c, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (obs_acc) k++;
        end

        // fully random traffic, occasional clear and reset
        repeat (1500) begin
            m = $urandom_range(0, 3);
            drive(1'($urandom_range(0, 3) != 0), {rv(), rv(), rv(), rv()}, m, rclamp(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 299) == 0));
        end

        // 6: saturation, clear priority, reset mid-flight
        repeat (3) drive(1'b0, '0, 0, '0, 1'b1, 1'b1, 1'b0);
        settle();
        chk("t6_cleared", W'(zero_count), W'(0));
        repeat (7) drive(1'b1, pk(-1, -2, 3, 4), 1, '0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t6_preload", W'(zero_count), W'(14));
        nb = pk(-1, -1, -1, -1);
        drive(1'b1, nb, 1, '0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t6_sat", W'(zero_count), W'(15));
        drive(1'b1, nb, 1, '0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t6_hold", W'(zero_count), W'(15));
        drive(1'b1, nb, 1, '0, 1'b1, 1'b1, 1'b0);
        settle();
        chk("t6_clr_wins", W'(zero_count), W'(0));
        repeat (3) idle(1'b1);
        drive(1'b1, nb, 1, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, nb, 1, '0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_inflight_cnt", W'(zero_count), W'(8));
        drive(1'b1, nb, 1, '0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t6_rst_valid", W'(bus.out_valid), W'(0));
        chk("t6_rst_count", W'(zero_count), W'(0));
        idle(1'b1);
        chk("t6_no_partial", W'(obs_v), W'(0));
        idle(1'b1);
        chk("t6_no_partial2", W'(obs_v), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
